sd_sector_server: RTL and testbench

- Host-side responder for the SCSI sector I/O interface that the data controller drives (io_lba/io_rd/io_wr/io_ack, sd_buff_*).
- Announces fixed-size images per device after reset.
- Serves 512-byte sector reads and writes from/to a word-addressed backing store, such as an SDRAM port or a sim memory model.
- Used in simulation benches and in standalone builds without the HPS.

---
 rtl/sd_sector_server_if.sv | 36 +++
 rtl/sd_sector_server.sv | 143 ++++++++++++++
 tb/tb_sd_sector_server.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_server_if.sv
// sd_sector_server_if: image mount, SCSI sector I/O and backing-store signals.
// The master side is the sector server; the slave side is the data controller plus memory.
interface sd_sector_server_if #(
    parameter int SCSI_DEVS = 2,
    parameter int SECT_W = 16,
    parameter int DEV_W = (SCSI_DEVS > 1) ? $clog2(SCSI_DEVS) : 1
);
    logic [SCSI_DEVS-1:0] img_mounted;
    logic [31:0] img_size;
    logic [SCSI_DEVS-1:0][31:0] io_lba;
    logic [SCSI_DEVS-1:0] io_rd;
    logic [SCSI_DEVS-1:0] io_wr;
    logic [SCSI_DEVS-1:0] io_ack;
    logic [7:0] sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic [SCSI_DEVS-1:0][15:0] sd_buff_din;
    logic sd_buff_wr;
    logic [DEV_W+SECT_W+7:0] mem_addr;
    logic mem_rd;
    logic mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic mem_ready;

    modport master (
        output img_mounted, img_size, io_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_wdata,
        input  io_lba, io_rd, io_wr, sd_buff_din, mem_rdata, mem_ready
    );

    modport slave (
        input  img_mounted, img_size, io_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_wdata,
        output io_lba, io_rd, io_wr, sd_buff_din, mem_rdata, mem_ready
    );
endinterface

// File: rtl/sd_sector_server.sv
// sd_sector_server: announces fixed-size images after reset, then serves 512-byte sector
// reads/writes for each device from a word-addressed backing store, round-robin.
module sd_sector_server #(
    parameter int SCSI_DEVS = 2,
    parameter int SECT_W = 16,
    parameter int DEV_W = (SCSI_DEVS > 1) ? $clog2(SCSI_DEVS) : 1
) (
    input logic clk32,
    input logic reset,
    sd_sector_server_if.master bus
);
    localparam logic [31:0] IMG_BYTES = 32'd1 << (SECT_W + 9);
    localparam logic [DEV_W-1:0] LAST_DEV = DEV_W'(SCSI_DEVS - 1);

    typedef enum logic [2:0] {MOUNT, IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_SAMPLE, WR_REQ, DONE} stateType;

    stateType state;
    logic phase;
    logic oor;
    logic [7:0] w;
    logic [SECT_W-1:0] lba;
    logic [DEV_W-1:0] d;
    logic [DEV_W-1:0] dev;
    logic [DEV_W-1:0] last;
    logic [DEV_W-1:0] cand;
    logic [DEV_W-1:0] grantDev;
    logic grantValid;
    logic grantOor;
    logic [31:0] grantLba;

    // Scan from the farthest candidate to the nearest so the device right after `last` wins.
    always_comb begin
        grantValid = 1'b0;
        grantDev = '0;
        cand = '0;
        for (int i = SCSI_DEVS; i >= 1; i--) begin
            cand = DEV_W'((int'(last) + i) % SCSI_DEVS);
            if (bus.io_rd[cand] | bus.io_wr[cand]) begin
                grantValid = 1'b1;
                grantDev = cand;
            end
        end
    end

    assign grantLba = bus.io_lba[grantDev];
    assign grantOor = |grantLba[31:SECT_W];

    always_ff @(posedge clk32) begin
        if (reset) begin
            state <= MOUNT;
            phase <= 1'b0;
            oor <= 1'b0;
            w <= '0;
            lba <= '0;
            d <= '0;
            dev <= '0;
            last <= LAST_DEV;
            bus.img_mounted <= '0;
            bus.img_size <= '0;
            bus.io_ack <= '0;
            bus.sd_buff_addr <= '0;
            bus.sd_buff_dout <= '0;
            bus.sd_buff_wr <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            bus.mem_wdata <= '0;
        end else begin
            bus.img_mounted <= '0;
            case (state)
                MOUNT: begin
                    bus.img_size <= IMG_BYTES;
                    phase <= !phase;
                    if (!phase) bus.img_mounted[d] <= 1'b1;
                    else if (d == LAST_DEV) state <= IDLE;
                    else d <= d + 1'b1;
                end
                IDLE: begin
                    if (grantValid) begin
                        dev <= grantDev;
                        last <= grantDev;
                        lba <= grantLba[SECT_W-1:0];
                        oor <= grantOor;
                        w <= '0;
                        bus.io_ack[grantDev] <= 1'b1;
                        if (bus.io_rd[grantDev]) begin
                            state <= RD_REQ;
                            bus.mem_rd <= !grantOor;
                            bus.mem_addr <= {grantDev, grantLba[SECT_W-1:0], 8'd0};
                        end else begin
                            state <= WR_ADDR;
                            bus.sd_buff_addr <= 8'd0;
                        end
                    end
                end
                RD_REQ: begin
                    if (bus.mem_ready || oor) begin
                        bus.mem_rd <= 1'b0;
                        bus.sd_buff_dout <= oor ? 16'h0000 : bus.mem_rdata;
                        bus.sd_buff_addr <= w;
                        bus.sd_buff_wr <= 1'b1;
                        state <= RD_PUT;
                    end
                end
                RD_PUT: begin
                    bus.sd_buff_wr <= 1'b0;
                    if (w == 8'hFF) begin
                        bus.io_ack <= '0;
                        state <= DONE;
                    end else begin
                        w <= w + 8'd1;
                        bus.mem_rd <= !oor;
                        bus.mem_addr <= {dev, lba, w + 8'd1};
                        state <= RD_REQ;
                    end
                end
                // The client registers din, so it is valid one cycle after the address is shown.
                WR_ADDR: state <= WR_SAMPLE;
                WR_SAMPLE: begin
                    bus.mem_wdata <= bus.sd_buff_din[dev];
                    bus.mem_addr <= {dev, lba, w};
                    bus.mem_wr <= !oor;
                    state <= WR_REQ;
                end
                WR_REQ: begin
                    if (bus.mem_ready || oor) begin
                        bus.mem_wr <= 1'b0;
                        if (w == 8'hFF) begin
                            bus.io_ack <= '0;
                            state <= DONE;
                        end else begin
                            w <= w + 8'd1;
                            bus.sd_buff_addr <= w + 8'd1;
                            state <= WR_ADDR;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_server.sv
// tb_sd_sector_server: random sector traffic against a sector-level model with a
// wait-state memory and a registered client.
module tb_sd_sector_server;
    localparam int N = 2;
    localparam int SW = 16;
    localparam int DW = 1;
    localparam int AW = DW + SW + 8;

    logic clk32 = 1'b0;
    logic reset = 1'b1;

    sd_sector_server_if #(.SCSI_DEVS(N), .SECT_W(SW), .DEV_W(DW)) bus ();
    sd_sector_server #(.SCSI_DEVS(N), .SECT_W(SW), .DEV_W(DW)) dut (
        .clk32(clk32),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk32 = ~clk32;

    int total = 0;
    int bad = 0;
    logic [15:0] salt;
    logic [15:0] key [N];
    int maxWait = 0;
    int waitCnt = 0;
    int lastServed = N - 1;
    int lastCycles = 0;
    int multiAck = 0;
    int rdWrBoth = 0;
    int rdCycles = 0;
    logic [N-1:0] prevAck = '0;
    logic [AW-1:0] rdAddrQ [$];
    logic [AW+15:0] wrQ [$];
    logic [23:0] strobeQ [$];
    int grantQ [$];
    logic [31:0] reqLba [N];
    logic [N-1:0] reqRd;
    logic [N-1:0] reqWr;

    function automatic logic [15:0] pat(input logic [AW-1:0] a);
        return a[15:0] ^ {a[AW-1:16], 7'd0} ^ salt;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory with random wait states plus a passive monitor, both evaluated mid-cycle.
    always @(negedge clk32) begin
        if (bus.mem_rd && bus.mem_wr) rdWrBoth <= rdWrBoth + 1;
        if ($countones(bus.io_ack) > 1) multiAck <= multiAck + 1;
        if (bus.mem_rd) rdCycles <= rdCycles + 1;
        if (bus.sd_buff_wr) strobeQ.push_back({bus.sd_buff_addr, bus.sd_buff_dout});
        for (int i = 0; i < N; i++) if (bus.io_ack[i] && !prevAck[i]) grantQ.push_back(i);
        prevAck <= bus.io_ack;
        if ((bus.mem_rd || bus.mem_wr) && waitCnt == 0) begin
            bus.mem_ready <= 1'b1;
            bus.mem_rdata <= bus.mem_rd ? pat(bus.mem_addr) : 16'($urandom);
            if (bus.mem_rd) rdAddrQ.push_back(bus.mem_addr);
            else wrQ.push_back({bus.mem_addr, bus.mem_wdata});
            waitCnt <= $urandom_range(maxWait, 0);
        end else begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= 16'($urandom);
            if (bus.mem_rd || bus.mem_wr) waitCnt <= waitCnt - 1;
        end
    end

    always @(posedge clk32)
        for (int i = 0; i < N; i++) bus.sd_buff_din[i] <= {8'h00, bus.sd_buff_addr} ^ key[i];

    task automatic checkZero(input string tag);
        check({tag, " ctrl"}, {bus.img_mounted, bus.io_ack, bus.sd_buff_wr, bus.mem_rd, bus.mem_wr}, 0);
        check({tag, " addr"}, {bus.sd_buff_addr, bus.mem_addr}, 0);
        check({tag, " data"}, {bus.sd_buff_dout, bus.mem_wdata}, 0);
        check({tag, " size"}, bus.img_size, 0);
    endtask

    task automatic mountCheck(input string tag);
        int cyc = 0;
        @(negedge clk32);
        reset = 1'b0;
        while (bus.img_mounted == '0 && cyc < 10) begin
            @(negedge clk32);
            cyc++;
        end
        check({tag, " start"}, 64'(cyc < 10), 1);
        for (int i = 0; i < 2 * N + 2; i++) begin
            check($sformatf("%s pulse%0d", tag, i), bus.img_mounted, (i % 2 == 0 && i / 2 < N) ? (1 << (i / 2)) : 0);
            if (i == 0) check({tag, " size"}, bus.img_size, 64'(1) << (SW + 9));
            @(negedge clk32);
        end
        check({tag, " ack"}, bus.io_ack, 0);
        lastServed = N - 1;
    endtask

    task automatic runGroup(input string tag);
        int order [$];
        int ptr;
        int c;
        int d;
        int errs;
        int cyc = 0;
        int s = strobeQ.size();
        int r = rdAddrQ.size();
        int wq = wrQ.size();
        int g = grantQ.size();
        int rc = rdCycles;
        bit anyRead = 1'b0;
        bit oor;
        logic [AW-9:0] base;
        logic [N-1:0] pend;
        logic [N-1:0] live;
        pend = reqRd | reqWr;
        ptr = lastServed;
        while (pend != '0) begin
            c = -1;
            for (int i = 1; i <= N; i++) if (c < 0 && pend[(ptr + i) % N]) c = (ptr + i) % N;
            order.push_back(c);
            pend[c] = 1'b0;
            ptr = c;
        end
        @(negedge clk32);
        for (int i = 0; i < N; i++) begin
            bus.io_lba[i] = reqLba[i];
            bus.io_rd[i] = reqRd[i];
            bus.io_wr[i] = reqWr[i];
        end
        live = reqRd | reqWr;
        while ((live != '0 || bus.io_ack != '0) && cyc < 5000) begin
            @(negedge clk32);
            cyc++;
            for (int i = 0; i < N; i++) if (bus.io_ack[i] && live[i]) begin
                bus.io_rd[i] = 1'b0;
                bus.io_wr[i] = 1'b0;
                live[i] = 1'b0;
            end
        end
        lastCycles = cyc;
        @(negedge clk32);
        check({tag, " done"}, 64'(cyc < 5000), 1);
        check({tag, " grants"}, grantQ.size() - g, order.size());
        foreach (order[k]) begin
            d = order[k];
            check($sformatf("%s grant%0d", tag, k), (g + k < grantQ.size()) ? grantQ[g + k] : -1, d);
            oor = |reqLba[d][31:SW];
            base = {DW'(d), reqLba[d][SW-1:0]};
            errs = 0;
            if (reqRd[d]) begin
                anyRead |= !oor;
                for (int x = 0; x < 256; x++) begin
                    if (s >= strobeQ.size() || strobeQ[s] !== {8'(x), oor ? 16'h0 : pat({base, 8'(x)})}) errs++;
                    s++;
                    if (!oor) begin
                        if (r >= rdAddrQ.size() || rdAddrQ[r] !== {base, 8'(x)}) errs++;
                        r++;
                    end
                end
                check($sformatf("%s rd dev%0d", tag, d), errs, 0);
            end else begin
                if (!oor) for (int x = 0; x < 256; x++) begin
                    if (wq >= wrQ.size() || wrQ[wq] !== {base, 8'(x), 16'(x) ^ key[d]}) errs++;
                    wq++;
                end
                check($sformatf("%s wr dev%0d", tag, d), errs, 0);
            end
        end
        check({tag, " extra"}, (strobeQ.size() - s) + (rdAddrQ.size() - r) + (wrQ.size() - wq), 0);
        if (!anyRead) check({tag, " no mem_rd"}, rdCycles - rc, 0);
        if (order.size() > 0) lastServed = order[order.size() - 1];
    endtask

    task automatic midReset();
        int cyc = 0;
        @(negedge clk32);
        bus.io_lba[0] = 32'($urandom_range(65535, 0));
        bus.io_rd[0] = 1'b1;
        while (!(bus.sd_buff_wr && bus.sd_buff_addr == 8'd100) && cyc < 2000) begin
            @(negedge clk32);
            cyc++;
            if (bus.io_ack[0]) bus.io_rd[0] = 1'b0;
        end
        check("midreset reach", 64'(cyc < 2000), 1);
        reset = 1'b1;
        bus.io_rd[0] = 1'b0;
        @(negedge clk32);
        checkZero("midreset");
        mountCheck("remount");
        reqRd = 2'b01;
        reqWr = '0;
        reqLba[0] = 32'($urandom_range(65535, 0));
        runGroup("after reset");
    endtask

    initial begin
        salt = 16'($urandom);
        for (int i = 0; i < N; i++) key[i] = 16'($urandom);
        bus.io_rd = '0;
        bus.io_wr = '0;
        bus.io_lba = '0;
        repeat (3) @(negedge clk32);
        checkZero("reset");
        mountCheck("mount");

        maxWait = 0;
        reqRd = 2'b01;
        reqWr = '0;
        reqLba[0] = 32'd5;
        reqLba[1] = 32'd0;
        runGroup("rd5");
        check("rd5 cycles", 64'(lastCycles <= 516), 1);

        maxWait = 3;
        reqRd = '0;
        reqWr = 2'b10;
        reqLba[1] = 32'h1234;
        key[1] = 16'hA5A5;
        runGroup("wr1234");

        maxWait = 1;
        reqRd = 2'b11;
        reqLba[0] = 32'($urandom_range(65535, 0));
        reqLba[1] = 32'($urandom_range(65535, 0));
        runGroup("pairA");
        reqRd = 2'b01;
        runGroup("solo0");
        reqRd = 2'b11;
        runGroup("pairB");

        reqRd = 2'b01;
        reqLba[0] = 32'h00010000;
        runGroup("oor rd");
        reqRd = '0;
        reqWr = 2'b01;
        runGroup("oor wr");

        for (int k = 0; k < 8; k++) begin
            maxWait = $urandom_range(2, 0);
            for (int i = 0; i < N; i++) begin
                c_op: begin
                    int op = $urandom_range(3, 0);
                    reqRd[i] = op[0];
                    reqWr[i] = op[1];
                end
                reqLba[i] = ($urandom_range(3, 0) == 0) ? {16'($urandom_range(65535, 1)), 16'($urandom)}
                                                        : 32'($urandom_range(65535, 0));
            end
            if ((reqRd | reqWr) == '0) reqWr[k % N] = 1'b1;
            runGroup($sformatf("rnd%0d", k));
        end

        midReset();
        check("single ack", multiAck, 0);
        check("rd wr exclusive", rdWrBoth, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
